// File: rtl/jt5205_seq.sv
// ADPCM sample sequencer: fetches ROM bytes over a cs/ok handshake and hands
// one 4-bit code per sample strobe to the MSM5205-style decoder.
//   state   | meaning
//   ST_IDLE | no playback; strobes and ROM acknowledges are ignored
//   ST_PLAY | playback active (busy=1), fetch engine running
module jt5205_seq #(
  parameter int AW       = 16,
  parameter int HI_FIRST = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] addr_start,
  input  logic [AW-1:0] addr_end,
  input  logic          vclk,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic [3:0]    din,
  output logic          busy,
  output logic          done,
  output logic          underrun
);

  typedef enum logic {ST_IDLE = 1'b0, ST_PLAY = 1'b1} state_t;

  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state, state_nx;
  logic [AW-1:0] end_q, end_nx, rom_addr_nx;
  logic [7:0]    nb, nb_nx, cur, cur_nx;
  logic          nbv, nbv_nx, phase, phase_nx, last, last_nx;
  logic          rom_cs_nx, done_nx, underrun_nx;
  logic [3:0]    din_nx;

  function automatic logic [3:0] first_nib(input logic [7:0] b);
    return (HI_FIRST != 0) ? b[7:4] : b[3:0];
  endfunction

  function automatic logic [3:0] second_nib(input logic [7:0] b);
    return (HI_FIRST != 0) ? b[3:0] : b[7:4];
  endfunction

  assign busy = (state == ST_PLAY);

  always_comb begin
    state_nx    = state;
    end_nx      = end_q;
    rom_addr_nx = rom_addr;
    rom_cs_nx   = rom_cs;
    nb_nx       = nb;
    nbv_nx      = nbv;
    cur_nx      = cur;
    phase_nx    = phase;
    last_nx     = last;
    din_nx      = din;
    done_nx     = 1'b0;
    underrun_nx = 1'b0;
    if (stop) begin
      state_nx  = ST_IDLE;
      rom_cs_nx = 1'b0;
      nbv_nx    = 1'b0;
      phase_nx  = 1'b0;
      last_nx   = 1'b0;
    end else if (start) begin
      end_nx   = addr_end;
      nbv_nx   = 1'b0;
      phase_nx = 1'b0;
      last_nx  = 1'b0;
      if (addr_end < addr_start) begin
        state_nx  = ST_IDLE;
        rom_cs_nx = 1'b0;
        done_nx   = 1'b1;
      end else begin
        state_nx    = ST_PLAY;
        rom_addr_nx = addr_start;
        // a request still pending from the old range is dropped for one cycle
        rom_cs_nx   = !rom_cs;
      end
    end else if (state == ST_PLAY) begin
      if (rom_cs && rom_ok) begin
        nb_nx     = rom_data;
        nbv_nx    = 1'b1;
        rom_cs_nx = 1'b0;
        // range end is a flag, so an all-ones addr_end never wraps into a match
        if (rom_addr == end_q) last_nx = 1'b1;
        else                   rom_addr_nx = rom_addr + ADDR_ONE;
      end else if (!rom_cs && !nbv && !last) begin
        rom_cs_nx = 1'b1;
      end
      if (vclk) begin
        if (!phase) begin
          if (nbv) begin
            cur_nx   = nb;
            nbv_nx   = 1'b0;
            phase_nx = 1'b1;
            din_nx   = first_nib(nb);
          end else begin
            underrun_nx = 1'b1;
          end
        end else begin
          din_nx   = second_nib(cur);
          phase_nx = 1'b0;
          if (last && !nbv && !rom_cs) begin
            state_nx = ST_IDLE;
            done_nx  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      end_q    <= '0;
      rom_addr <= '0;
      rom_cs   <= 1'b0;
      nb       <= '0;
      nbv      <= 1'b0;
      cur      <= '0;
      phase    <= 1'b0;
      last     <= 1'b0;
      din      <= 4'd0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_nx;
      end_q    <= end_nx;
      rom_addr <= rom_addr_nx;
      rom_cs   <= rom_cs_nx;
      nb       <= nb_nx;
      nbv      <= nbv_nx;
      cur      <= cur_nx;
      phase    <= phase_nx;
      last     <= last_nx;
      din      <= din_nx;
      done     <= done_nx;
      underrun <= underrun_nx;
    end
  end

endmodule

// File: tb/tb_jt5205_seq.sv
// Bench for jt5205_seq: two instances (AW=16 high-first, AW=4 low-first)
// driven by one ROM responder and strobe generator, checked against a
// byte-range -> nibble-stream model.
module tb_jt5205_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, vclk = 1'b0, rom_ok = 1'b0, sel = 1'b0;
  logic [15:0] addr_start = '0, addr_end = '0;
  logic [7:0]  rom_data = '0;

  logic [15:0] rom_addr_a;
  logic [3:0]  rom_addr_b, din_a, din_b;
  logic        rom_cs_a, rom_cs_b, busy_a, busy_b, done_a, done_b, ur_a, ur_b;

  logic [15:0] rom_addr;
  logic [3:0]  din;
  logic        rom_cs, busy, done, underrun;

  assign rom_addr = sel ? {12'd0, rom_addr_b} : rom_addr_a;
  assign rom_cs   = sel ? rom_cs_b : rom_cs_a;
  assign din      = sel ? din_b    : din_a;
  assign busy     = sel ? busy_b   : busy_a;
  assign done     = sel ? done_b   : done_a;
  assign underrun = sel ? ur_b     : ur_a;

  always #5 clk = ~clk;

  jt5205_seq #(.AW(16), .HI_FIRST(1)) u_hi (
    .clk(clk), .rst(rst), .start(start && !sel), .stop(stop && !sel),
    .addr_start(addr_start), .addr_end(addr_end), .vclk(vclk && !sel),
    .rom_addr(rom_addr_a), .rom_cs(rom_cs_a), .rom_data(rom_data),
    .rom_ok(rom_ok && !sel), .din(din_a), .busy(busy_a), .done(done_a),
    .underrun(ur_a));

  jt5205_seq #(.AW(4), .HI_FIRST(0)) u_lo (
    .clk(clk), .rst(rst), .start(start && sel), .stop(stop && sel),
    .addr_start(addr_start[3:0]), .addr_end(addr_end[3:0]), .vclk(vclk && sel),
    .rom_addr(rom_addr_b), .rom_cs(rom_cs_b), .rom_data(rom_data),
    .rom_ok(rom_ok && sel), .din(din_b), .busy(busy_b), .done(done_b),
    .underrun(ur_b));

  int          checks = 0, errors = 0;
  int          done_cnt = 0, ur_cnt = 0, lat = 2, per = 48, vcnt = 0, wcnt = 0;
  logic        vclk_en = 1'b0, late_ok = 1'b0, cs_prev = 1'b0;
  logic [3:0]  din_prev = '0;
  logic [7:0]  mem [65536];
  logic [3:0]  obs[$], exp_codes[$];
  logic [15:0] fetch[$], exp_fetch[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: apply inputs at posedge, observe at negedge, then compute the
  // ROM response and strobe for the next posedge.
  task automatic tick();
    logic v_app, b_app;
    v_app = vclk;
    b_app = busy;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    if (done) done_cnt++;
    if (underrun) begin
      ur_cnt++;
      check_val("underrun_din_hold", din, din_prev);
    end else if (v_app && b_app) begin
      obs.push_back(din);
    end
    din_prev = din;
    rom_ok = 1'b0;
    if (late_ok) begin
      rom_ok   = 1'b1;
      rom_data = 8'hEE;
    end else if (rom_cs) begin
      if (!cs_prev) fetch.push_back(rom_addr);
      if (wcnt >= lat) begin
        rom_ok   = 1'b1;
        rom_data = mem[rom_addr];
        wcnt     = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
    cs_prev = rom_cs;
    vclk = 1'b0;
    if (vclk_en) begin
      vcnt++;
      if (vcnt >= per) begin
        vclk = 1'b1;
        vcnt = 0;
      end
    end
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check_val("rst_rom_addr", rom_addr, 0);
    check_val("rst_rom_cs", rom_cs, 0);
    check_val("rst_din", din, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_underrun", underrun, 0);
    #1 rst = 1'b0;
    wcnt = 0; cs_prev = 1'b0; din_prev = '0;
    vclk = 1'b0; vclk_en = 1'b0; rom_ok = 1'b0;
  endtask

  task automatic begin_play(input logic s, input logic [15:0] a0, input logic [15:0] a1,
                            input int l, input int p);
    logic [15:0] ad;
    logic [7:0]  b;
    logic        cs_before;
    int          n;
    exp_codes.delete(); exp_fetch.delete(); obs.delete(); fetch.delete();
    n = int'(a1 - a0) + 1;
    for (int k = 0; k < n; k++) begin
      ad = a0 + 16'(k);
      b  = mem[ad];
      exp_fetch.push_back(ad);
      if (s) begin
        exp_codes.push_back(b[3:0]); exp_codes.push_back(b[7:4]);
      end else begin
        exp_codes.push_back(b[7:4]); exp_codes.push_back(b[3:0]);
      end
    end
    sel = s; lat = l; per = p; done_cnt = 0; ur_cnt = 0;
    cs_before = rom_cs;
    addr_start = a0; addr_end = a1; start = 1'b1;
    vclk = 1'b0; vcnt = 0; vclk_en = 1'b1;
    tick();
    check_val("start_busy", busy, 1);
    check_val("start_addr", rom_addr, a0);
    check_val("start_cs", rom_cs, !cs_before);
  endtask

  task automatic finish_play(input int exp_ur);
    logic [3:0] hold;
    int         budget;
    budget = (exp_codes.size() + 4) * per + 4 * lat + 200;
    for (int i = 0; i < budget && busy; i++) tick();
    check_val("end_busy", busy, 0);
    check_val("done_count", done_cnt, 1);
    check_val("underrun_count", ur_cnt, exp_ur);
    check_val("code_count", obs.size(), exp_codes.size());
    for (int i = 0; i < obs.size() && i < exp_codes.size(); i++)
      check_val("code", obs[i], exp_codes[i]);
    check_val("fetch_count", fetch.size(), exp_fetch.size());
    for (int i = 0; i < fetch.size() && i < exp_fetch.size(); i++)
      check_val("fetch_addr", fetch[i], exp_fetch[i]);
    hold = din;
    for (int i = 0; i < 2 * per; i++) tick();
    vclk_en = 1'b0;
    check_val("idle_din_hold", din, hold);
    check_val("idle_done_count", done_cnt, 1);
  endtask

  initial begin
    logic        s;
    logic [15:0] a0, a1;
    int          len, p, l;

    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0010] = 8'hA5; mem[16'h0011] = 8'h3C;
    mem[16'h0002] = 8'hA5; mem[16'h0003] = 8'h3C;

    repeat (2) @(negedge clk);
    check_val("reset_rom_addr", rom_addr, 0);
    check_val("reset_rom_cs", rom_cs, 0);
    check_val("reset_din", din, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_done", done, 0);
    check_val("reset_underrun", underrun, 0);
    rst = 1'b0;
    tick();
    check_val("post_reset_busy", busy, 0);

    // basic play, high nibble first
    begin_play(1'b0, 16'h0010, 16'h0011, 2, 48);
    finish_play(0);

    // reset while a fetch is pending, then a normal play
    begin_play(1'b0, 16'h0010, 16'h0011, 1000, 48);
    repeat (3) tick();
    check_val("prereset_cs", rom_cs, 1);
    do_reset();
    begin_play(1'b0, 16'h0010, 16'h0011, 2, 48);
    finish_play(0);

    // slow ROM: two strobes before the first byte, one before the second
    do_reset();
    begin_play(1'b0, 16'h0010, 16'h0011, 120, 48);
    finish_play(3);

    // low nibble first, and single-byte range at the top of a 4-bit space
    begin_play(1'b1, 16'h0002, 16'h0003, 2, 48);
    finish_play(0);
    begin_play(1'b1, 16'h000F, 16'h000F, 3, 24);
    finish_play(0);

    // empty range
    sel = 1'b0; vclk_en = 1'b0; fetch.delete(); done_cnt = 0;
    addr_start = 16'h0005; addr_end = 16'h0004; start = 1'b1;
    tick();
    check_val("empty_done", done, 1);
    check_val("empty_busy", busy, 0);
    check_val("empty_cs", rom_cs, 0);
    repeat (5) tick();
    check_val("empty_done_count", done_cnt, 1);
    check_val("empty_fetch_count", fetch.size(), 0);

    // stop during a pending fetch, then a late acknowledge
    begin_play(1'b0, 16'h0020, 16'h0021, 1000, 48);
    repeat (3) tick();
    check_val("stop_pre_cs", rom_cs, 1);
    vclk_en = 1'b0;
    stop = 1'b1;
    tick();
    check_val("stop_cs", rom_cs, 0);
    check_val("stop_busy", busy, 0);
    late_ok = 1'b1;
    tick();
    late_ok = 1'b0;
    repeat (4) tick();
    check_val("stop_late_busy", busy, 0);
    check_val("stop_late_cs", rom_cs, 0);
    check_val("stop_done_count", done_cnt, 0);

    // start and stop together
    done_cnt = 0;
    addr_start = 16'h0050; addr_end = 16'h0051; start = 1'b1; stop = 1'b1;
    tick();
    check_val("startstop_busy", busy, 0);
    check_val("startstop_cs", rom_cs, 0);
    addr_start = 16'h0005; addr_end = 16'h0004; start = 1'b1; stop = 1'b1;
    repeat (3) tick();
    check_val("startstop_done_count", done_cnt, 0);

    // restart mid-play
    begin_play(1'b0, 16'h0030, 16'h0035, 2, 20);
    repeat (50) tick();
    check_val("mid_busy", busy, 1);
    begin_play(1'b0, 16'h0040, 16'h0041, 2, 20);
    finish_play(0);

    // randomized ranges, latencies and strobe periods
    for (int it = 0; it < 12; it++) begin
      s   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 4);
      p   = $urandom_range(8, 40);
      l   = $urandom_range(0, p - 3);
      if (s) begin
        a0 = 16'($urandom_range(0, 15));
        a1 = a0 + 16'(len - 1);
        if (a1 > 16'h000F) a1 = 16'h000F;
      end else begin
        if ($urandom_range(0, 2) == 0) a0 = 16'hFFFF - 16'($urandom_range(0, 3));
        else                           a0 = 16'($urandom);
        a1 = a0 + 16'(len - 1);
        if (a1 < a0) a1 = 16'hFFFF;
      end
      begin_play(s, a0, a1, l, p);
      finish_play(0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt5205_seq.md
Name: jt5205_seq

Overview:
- ADPCM sample sequencer for the MSM5205-compatible decoder.
- Fetches bytes from a ROM address range through a cs/ok handshake and splits each byte into two 4-bit codes.
- Presents one code to the decoder per sample strobe. The strobe is the one-cycle clk_en pulse produced by the sample-rate timing block.
- Handles start/stop, range end, restart while busy and buffer underrun.

Parameters:
AW  16  ROM address width
HI_FIRST  1  1: high nibble played first; 0: low nibble first

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; latch addr_start/addr_end and begin playback
stop  in  1  one-cycle pulse; abort playback
addr_start  in  AW  first byte address
addr_end  in  AW  last byte address, inclusive
vclk  in  1  sample strobe, one-cycle pulse
rom_addr  out  AW  ROM byte address
rom_cs  out  1  ROM request, held until rom_ok
rom_data  in  8  ROM read data, valid when rom_ok=1
rom_ok  in  1  ROM acknowledge
din  out  4  ADPCM code to decoder
busy  out  1  playback active
done  out  1  one-cycle pulse at natural end of range
underrun  out  1  one-cycle pulse when vclk finds no data

Behaviour:
- Reset values: rom_addr=0, rom_cs=0, din=0, busy=0, done=0, underrun=0. Internal state is also cleared: next-byte buffer empty (nbv=0), phase=0, last=0.
- Start:
  - Cycle N start=1 -> cycle N+1: busy=1, rom_addr=addr_start, rom_cs=1, buffers cleared, phase=0, last=0.
  - If addr_end<addr_start, the range is empty: busy stays 0, no fetch, done=1 at N+1.
- Fetch engine, active while busy:
  - Request condition: rom_cs raised when nbv=0, last=0 and no request is pending.
  - Capture: on a cycle with rom_cs=1 and rom_ok=1, nb<=rom_data and nbv<=1, and rom_cs drops the next cycle.
  - Addressing: if rom_addr==addr_end then last<=1, else rom_addr<=rom_addr+1.
  - Wrap: addr_end may be all-ones. Range end is tracked by the last flag, never by comparing against rom_addr+1, so wrap-around cannot corrupt it.
  - rom_ok while rom_cs=0 is ignored.
- Playback on vclk while busy:
  - phase=0, nbv=1: cur<=nb, nbv<=0, phase<=1, din<=first nibble of nb. The first nibble is [7:4] if HI_FIRST, else [3:0].
  - phase=0, nbv=0: underrun=1 for one cycle, din holds its value, phase unchanged.
  - phase=1: din<=second nibble of cur, phase<=0. If last=1 and nbv=0 and no request is pending, the range is exhausted. On the next cycle busy=0 and done=1.
  - vclk while not busy: ignored, din holds.
  - Update timing: din updates the cycle after vclk and holds between strobes.
- Prefetch: the next byte is requested as soon as nb is consumed. The ROM therefore has up to two sample periods to respond before an underrun occurs.
- Stop:
  - Next cycle: busy=0, rom_cs=0, buffers cleared.
  - No done pulse. din holds its last value.
  - An in-flight rom_ok arriving after the stop is ignored.
- Restart: start while busy behaves as a fresh start. Any pending request is dropped: rom_cs goes low for at least one cycle before the new request.
- Simultaneous events:
  - stop with start in the same cycle: stop wins.
  - vclk with rom_ok in the same cycle: capture and consume are resolved in the same cycle. A vclk at phase=0 with nbv=0 and rom_ok=1 still reports underrun, and the captured byte is kept for the next vclk.
  - vclk with start in the same cycle: start wins and vclk is ignored.
- Reset asserted mid-operation: immediate return to reset values, with no done pulse.

Test Plan:
- Basic play: range 0x0010..0x0011 holding 0xA5, 0x3C; rom_ok 2 cycles after cs; vclk every 48 cycles.
  -> din sequence A,5,3,C, then done=1 exactly once and busy=0. Two ROM requests, at addresses 0x10 and 0x11.
- HI_FIRST=0, same ROM data -> din sequence 5,A,C,3.
- Underrun: rom_ok delayed 120 cycles, vclk every 48 cycles.
  -> underrun pulses before the first code, din holds 0, then A,5 play correctly. No extra done pulse.
- Wrap and empty range:
  - AW=4, range 0xF..0xF -> one fetch at 0xF, two codes, then done.
  - Range 0x5..0x4 -> done one cycle after start, rom_cs never asserted.
- Stop/restart:
  - stop during a pending fetch -> rom_cs=0 next cycle, a late rom_ok is ignored, no done.
  - start+stop in the same cycle -> busy stays 0.
  - start mid-play -> rom_addr reloads to the new addr_start.
- Reset mid-fetch: rst pulsed while rom_cs=1 -> all outputs 0 immediately (asynchronous). Next start behaves normally.
